// File: rtl/tlc5941_receiver.sv
// rtl/tlc5941_receiver.sv - cycle-accurate TLC5941 16-channel LED driver receiver
// Shifts GS/DC serial data on sclk, latches on xlat and drives per-channel PWM enables from gsclk/blank.
module tlc5941_receiver #(
  parameter int CHANNELS = 16,
  parameter int GS_BITS  = 12,
  parameter int DC_BITS  = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         sclk,
  input  logic                         sin,
  input  logic                         mode,
  input  logic                         xlat,
  input  logic                         blank,
  input  logic                         gsclk,
  output logic                         sout,
  output logic [CHANNELS-1:0]          out_on,
  output logic [CHANNELS*GS_BITS-1:0]  gs_data,
  output logic [CHANNELS*DC_BITS-1:0]  dc_data,
  output logic                         gs_latched,
  output logic                         dc_latched,
  output logic [9:0]                   bit_count
);

  localparam int GS_W  = CHANNELS * GS_BITS;
  localparam int DC_W  = CHANNELS * DC_BITS;
  localparam int CNT_W = GS_BITS + 1;
  // One past the largest grayscale value; the counter parks here until the next blank.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1 << GS_BITS);

  logic             sclk_q, xlat_q, gsclk_q;
  logic [GS_W-1:0]  gs_sr;
  logic [DC_W-1:0]  dc_sr;
  logic [CNT_W-1:0] gs_cnt;
  logic             sclk_edge, xlat_edge, gsclk_edge;

  assign sclk_edge  = sclk  & ~sclk_q;
  assign xlat_edge  = xlat  & ~xlat_q;
  assign gsclk_edge = gsclk & ~gsclk_q;

  assign sout = mode ? dc_sr[DC_W-1] : gs_sr[GS_W-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_q     <= 1'b0;
      xlat_q     <= 1'b0;
      gsclk_q    <= 1'b0;
      gs_sr      <= '0;
      dc_sr      <= '0;
      gs_data    <= '0;
      dc_data    <= '0;
      gs_latched <= 1'b0;
      dc_latched <= 1'b0;
      bit_count  <= '0;
      gs_cnt     <= '0;
      out_on     <= '0;
    end else begin
      sclk_q  <= sclk;
      xlat_q  <= xlat;
      gsclk_q <= gsclk;

      if (sclk_edge) begin
        if (mode) dc_sr <= {dc_sr[DC_W-2:0], sin};
        else      gs_sr <= {gs_sr[GS_W-2:0], sin};
      end

      // Latch reads the pre-shift register; xlat also wins over a coincident sclk for bit_count.
      if (xlat_edge) begin
        bit_count <= '0;
        if (mode) dc_data <= dc_sr;
        else      gs_data <= gs_sr;
      end else if (sclk_edge && bit_count != 10'h3FF) begin
        bit_count <= bit_count + 10'd1;
      end

      gs_latched <= xlat_edge & ~mode;
      dc_latched <= xlat_edge & mode;

      if (blank)                               gs_cnt <= '0;
      else if (gsclk_edge && gs_cnt != CNT_MAX) gs_cnt <= gs_cnt + CNT_W'(1);

      for (int n = 0; n < CHANNELS; n++)
        out_on[n] <= ~blank & (gs_cnt < {1'b0, gs_data[n*GS_BITS +: GS_BITS]});
    end
  end

endmodule
